// File: rtl/apb_mem_slave_ws_if.sv
// APB bus bundle for apb_mem_slave_ws.
// The master drives the request signals and the slave drives the completion signals.
interface apb_mem_slave_ws_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [WIDTH-1:0]      pwdata;
    logic [WIDTH/8-1:0]    pstrb;
    logic [WIDTH-1:0]      prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_slave_ws.sv
// APB register-file memory slave with configurable wait states, byte strobes,
// alignment and range checking, registered response and a saturating error counter.
module apb_mem_slave_ws #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    apb_mem_slave_ws_if.slave   bus,
    output logic [7:0]          err_cnt
);
    localparam int NB  = WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]            state;
    logic [3:0]            cnt;
    logic                  err_lat;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IW-1:0]         idx;
    logic                  addr_err;
    logic                  setup;
    logic                  resp_err;
    logic [WIDTH-1:0]      rd_word;
    logic [WIDTH-1:0]      resp_data;

    assign word_addr = bus.paddr >> LSB;
    assign idx       = word_addr[IW-1:0];
    // Extra MSB keeps the range compare correct when DEPTH equals 2**ADDR_WIDTH.
    assign addr_err  = (|(bus.paddr & LSB_MASK)) ||
                       ({1'b0, word_addr} >= (ADDR_WIDTH + 1)'(DEPTH));
    assign setup     = bus.psel && !bus.penable;
    assign resp_err  = (state == ACCESS && bus.penable) ? err_lat : addr_err;
    assign rd_word   = addr_err ? '0 : mem[idx];
    assign resp_data = (!bus.pwrite && !resp_err) ? rd_word : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            err_lat     <= 1'b0;
            err_cnt     <= '0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state   <= ACCESS;
                        cnt     <= 4'(WAIT_STATES);
                        err_lat <= addr_err;
                        if (WAIT_STATES == 0) begin
                            bus.pready  <= 1'b1;
                            bus.pslverr <= resp_err;
                            bus.prdata  <= resp_data;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.psel) begin
                        state       <= IDLE;
                        bus.pready  <= 1'b0;
                        bus.pslverr <= 1'b0;
                        bus.prdata  <= '0;
                    end else if (!bus.penable) begin
                        cnt         <= 4'(WAIT_STATES);
                        err_lat     <= addr_err;
                        bus.pready  <= (WAIT_STATES == 0);
                        bus.pslverr <= (WAIT_STATES == 0) ? resp_err : 1'b0;
                        bus.prdata  <= (WAIT_STATES == 0) ? resp_data : '0;
                    end else if (bus.pready) begin
                        if (bus.pwrite && !err_lat) begin
                            for (int unsigned b = 0; b < NB; b++)
                                if (bus.pstrb[b]) mem[idx][8*b +: 8] <= bus.pwdata[8*b +: 8];
                        end
                        if (bus.pslverr && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        state       <= IDLE;
                        bus.pready  <= 1'b0;
                        bus.pslverr <= 1'b0;
                        bus.prdata  <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            bus.pready  <= 1'b1;
                            bus.pslverr <= resp_err;
                            bus.prdata  <= resp_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Scoreboard bench for apb_mem_slave_ws: drivers queue expected responses,
// per-DUT monitors pop and compare whenever pready is seen high.
module tb_apb_mem_slave_ws;
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clk;
    logic rst_n;
    logic [7:0] err_cnt_a;
    logic [7:0] err_cnt_b;
    int n_checks = 0;
    int n_pass   = 0;
    resp_t qa[$];
    resp_t qb[$];

    apb_mem_slave_ws_if #(.ADDR_WIDTH(8), .WIDTH(32)) bus_a ();
    apb_mem_slave_ws_if #(.ADDR_WIDTH(8), .WIDTH(32)) bus_b ();

    apb_mem_slave_ws #(.ADDR_WIDTH(8), .WIDTH(32), .DEPTH(32), .WAIT_STATES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .err_cnt(err_cnt_a)
    );
    apb_mem_slave_ws #(.ADDR_WIDTH(8), .WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .err_cnt(err_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_bus(input int sel, input logic ps, input logic pe, input logic [7:0] addr,
                           input logic wr, input logic [31:0] wd, input logic [3:0] st);
        if (sel == 0) begin
            bus_a.psel = ps; bus_a.penable = pe; bus_a.paddr = addr;
            bus_a.pwrite = wr; bus_a.pwdata = wd; bus_a.pstrb = st;
        end else begin
            bus_b.psel = ps; bus_b.penable = pe; bus_b.paddr = addr;
            bus_b.pwrite = wr; bus_b.pwdata = wd; bus_b.pstrb = st;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the completion edge with the bus idle.
    task automatic xfer(input int sel, input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_d, input logic exp_e);
        int n;
        int exp_n;
        logic rdy;
        resp_t r;
        r.data = exp_d;
        r.err  = exp_e;
        if (sel == 0) qa.push_back(r); else qb.push_back(r);
        exp_n = (sel == 0) ? 3 : 1;
        set_bus(sel, 1'b1, 1'b0, addr, wr, wd, st);
        @(posedge clk); #1;
        set_bus(sel, 1'b1, 1'b1, addr, wr, wd, st);
        n = 1;
        rdy = (sel == 0) ? bus_a.pready : bus_b.pready;
        while (!rdy && n < 20) begin
            @(posedge clk); #1;
            n++;
            rdy = (sel == 0) ? bus_a.pready : bus_b.pready;
        end
        check("pready_cycle", 32'(n), 32'(exp_n));
        @(posedge clk); #1;
        set_bus(sel, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
    endtask

    always @(negedge clk) begin
        resp_t r;
        if (bus_a.pready) begin
            if (qa.size() == 0) check("a_unexpected_pready", 32'd1, 32'd0);
            else begin
                r = qa.pop_front();
                check("a_prdata", bus_a.prdata, r.data);
                check("a_pslverr", 32'(bus_a.pslverr), 32'(r.err));
            end
        end
        if (bus_b.pready) begin
            if (qb.size() == 0) check("b_unexpected_pready", 32'd1, 32'd0);
            else begin
                r = qb.pop_front();
                check("b_prdata", bus_b.prdata, r.data);
                check("b_pslverr", 32'(bus_b.pslverr), 32'(r.err));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rdy;
        int n;
        rst_n = 1'b0;
        set_bus(0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        set_bus(1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 32'(bus_a.pready), 32'd0);
        check("rst_pslverr", 32'(bus_a.pslverr), 32'd0);
        check("rst_prdata", bus_a.prdata, 32'h0);
        check("rst_err_cnt", 32'(err_cnt_a), 32'd0);
        check("rst_b_pready", 32'(bus_b.pready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full write then read
        xfer(0, 8'h08, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xfer(0, 8'h08, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Partial strobes over existing data
        xfer(0, 8'h04, 1'b1, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0);
        xfer(0, 8'h04, 1'b1, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        xfer(0, 8'h04, 1'b0, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);
        xfer(0, 8'h08, 1'b1, 32'h12345678, 4'h0, 32'h0, 1'b0);
        xfer(0, 8'h08, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Misaligned and out-of-range errors
        xfer(0, 8'h06, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(0, 8'h80, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
        xfer(0, 8'h05, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        check("err_cnt_after_errors", 32'(err_cnt_a), 32'd3);
        xfer(0, 8'h04, 1'b0, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);
        xfer(0, 8'h7C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

        // Zero wait states, back-to-back
        xfer(1, 8'h10, 1'b1, 32'hA5A55A5A, 4'hF, 32'h0, 1'b0);
        xfer(1, 8'h10, 1'b0, 32'h0, 4'h0, 32'hA5A55A5A, 1'b0);
        xfer(1, 8'h84, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        check("b_err_cnt", 32'(err_cnt_b), 32'd1);

        // Abort in the second access cycle
        set_bus(0, 1'b1, 1'b0, 8'h0C, 1'b1, 32'h55AA55AA, 4'hF);
        @(posedge clk); #1;
        set_bus(0, 1'b1, 1'b1, 8'h0C, 1'b1, 32'h55AA55AA, 4'hF);
        @(posedge clk); #1;
        set_bus(0, 1'b0, 1'b0, 8'h0C, 1'b1, 32'h55AA55AA, 4'hF);
        for (int i = 0; i < 4; i++) begin
            check("abort_pready", 32'(bus_a.pready), 32'd0);
            @(posedge clk); #1;
        end
        xfer(0, 8'h0C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        check("abort_err_cnt", 32'(err_cnt_a), 32'd3);

        // Saturate the error counter
        for (int i = 0; i < 300; i++) xfer(0, 8'h06, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        check("err_cnt_saturated", 32'(err_cnt_a), 32'd255);

        // Reset while a read completes (response intentionally not queued)
        set_bus(0, 1'b1, 1'b0, 8'h08, 1'b0, 32'h0, 4'h0);
        @(posedge clk); #1;
        set_bus(0, 1'b1, 1'b1, 8'h08, 1'b0, 32'h0, 4'h0);
        n = 1;
        rdy = bus_a.pready;
        while (!rdy && n < 20) begin
            @(posedge clk); #1;
            n++;
            rdy = bus_a.pready;
        end
        check("pre_rst_pready_cycle", 32'(n), 32'd3);
        check("pre_rst_prdata", bus_a.prdata, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pready", 32'(bus_a.pready), 32'd0);
        check("async_rst_prdata", bus_a.prdata, 32'h0);
        check("async_rst_err_cnt", 32'(err_cnt_a), 32'd0);
        set_bus(0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 32; w++) xfer(0, 8'(w * 4), 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1, 8'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_mem_slave_ws.md
Name: apb_mem_slave_ws

Overview:
Parametrised APB slave backed by a register-file memory. Adds configurable wait states, byte-lane write strobes, byte addressing with alignment and range checks, and PSLVERR signalling. Registered, glitch-free PREADY/PRDATA/PSLVERR outputs and a saturating error counter. Sits on the peripheral APB segment behind the bridge as the generic scratch/config memory.

Parameters:
ADDR_WIDTH, 8, byte-address width of paddr
WIDTH, 32, data width in bits; must be 8, 16, 32 or 64
DEPTH, 32, number of WIDTH-bit words; DEPTH*WIDTH/8 <= 2**ADDR_WIDTH
WAIT_STATES, 2, access-phase wait cycles before pready (0..15)

Ports:
clk  in  1  APB clock, rising-edge
rst_n  in  1  asynchronous active-low reset
paddr  in  ADDR_WIDTH  byte address
pwrite  in  1  1=write, 0=read
psel  in  1  slave select
penable  in  1  access-phase strobe
pwdata  in  WIDTH  write data
pstrb  in  WIDTH/8  byte-lane write enables
prdata  out  WIDTH  read data, valid when pready=1 on a read
pready  out  1  transfer completion
pslverr  out  1  transfer error, valid only when pready=1
err_cnt  out  8  saturating count of completed error transfers

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pready=0, pslverr=0, prdata=0, err_cnt=0, wait counter=0, all memory words=0. Any in-flight transfer is dropped without a write.
- LSB = log2(WIDTH/8). Word index = paddr[ADDR_WIDTH-1:LSB].
- Error conditions, evaluated from paddr/pwrite sampled at setup: misaligned (paddr[LSB-1:0]!=0, only when LSB>0) or out of range (index >= DEPTH).
- FSM states:
  - IDLE, on an edge with psel=1 and penable=0 (setup): go to ACCESS and load cnt=WAIT_STATES. If WAIT_STATES=0, also set pready=1 and latch the response (see below).
  - ACCESS with pready=0 and psel=1, penable=1: decrement cnt. When cnt goes 1->0, set pready=1 and latch the response at that edge.
  - ACCESS with pready=1 (completion edge, psel=penable=1): commit the write if one applies; pready<=0, pslverr<=0, prdata<=0, go to IDLE.
  - ACCESS with psel=0 (abort): go to IDLE, pready=0, no write, err_cnt unchanged.
  - ACCESS with psel=1 and penable=0 (new setup mid-transfer): restart as a fresh setup, reload cnt and re-evaluate the error conditions.
- Access-phase length: exactly WAIT_STATES+1 cycles with penable=1. pready is high only in the last of these and is 0 at all other times.
- Latched response:
  - Read, no error: prdata=mem[index].
  - Error: pslverr=1, prdata=0.
  - Write: prdata=0.
- Write commit: at the completion edge only. Byte lane i (bits 8i+7:8i) updated iff pstrb[i]=1. pstrb=0 is a legal no-op write. pstrb is ignored on reads. Writes with an error never modify memory.
- err_cnt increments by 1 at each completion edge with pslverr=1 and saturates at 255.
- Back-to-back: a setup in the cycle right after completion is accepted from IDLE with no idle gap required. A read that follows a write returns the updated data.
- paddr, pwrite, pwdata and pstrb are resampled at the completion edge for the write. They must be held stable by the master per APB rules.

Test Plan:
1. WIDTH=32, WAIT_STATES=2: write 0xDEADBEEF to 0x08 with pstrb=0xF, then read 0x08 -> pready high on the 3rd access cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
2. Write 0x11223344 to 0x04 with pstrb=0b0101 over existing 0xAABBCCDD -> subsequent read returns 0xAA22CC44.
3. Read 0x06 (misaligned) and write to 0x80 (index 32 >= DEPTH) -> pslverr=1 with pready, prdata=0, memory unchanged, err_cnt=2.
4. WAIT_STATES=0: back-to-back write then read to 0x10, no idle cycle between -> pready high in the first access cycle of each, read returns the written value.
5. Deassert psel in the 2nd access cycle of a write to 0x0C -> no pready, FSM returns to IDLE, read of 0x0C returns the prior value 0.
6. Assert rst_n=0 mid-access after 300 prior error transfers -> outputs go to 0 immediately, err_cnt=0 (it had saturated at 255 before reset), all words read back as 0.
